// File: rtl/alu_cmd_queue.sv
// Command FIFO feeding a combinational ALU, with a registered, handshaked result stage.
// Optional ALU_CMD_ERR_EN adds out_err, which flags the unsupported opcode class 2'b11.
module alu_cmd_queue #(
    parameter int DATA_WIDTH   = 8,
    parameter int OPCODE_WIDTH = 4,
    parameter int DEPTH        = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [DATA_WIDTH-1:0]        in_a,
    input  logic [DATA_WIDTH-1:0]        in_b,
    input  logic [OPCODE_WIDTH-1:0]      in_opcode,
    output logic [DATA_WIDTH-1:0]        alu_a,
    output logic [DATA_WIDTH-1:0]        alu_b,
    output logic [OPCODE_WIDTH-1:0]      alu_opcode,
    input  logic [DATA_WIDTH-1:0]        alu_result,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DATA_WIDTH-1:0]        out_result,
    output logic [OPCODE_WIDTH-1:0]      out_opcode,
    output logic [$clog2(DEPTH+1)-1:0]   count
`ifdef ALU_CMD_ERR_EN
    ,
    output logic                         out_err
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    typedef struct packed {
        logic [DATA_WIDTH-1:0]   a;
        logic [DATA_WIDTH-1:0]   b;
        logic [OPCODE_WIDTH-1:0] opcode;
    } cmd_t;

    cmd_t             mem [DEPTH];
    cmd_t             head;
    cmd_t             wr_cmd;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             empty;
    logic             push;
    logic             pop;

    // No full-bypass: a full queue refuses pushes even while it pops.
    assign empty    = (count == '0);
    assign in_ready = (count != CNT_W'(DEPTH));
    assign push     = in_valid && in_ready;
    assign pop      = !empty && (!out_valid || out_ready);

    assign head   = mem[rd_ptr];
    assign wr_cmd = '{a: in_a, b: in_b, opcode: in_opcode};

    assign alu_a      = empty ? '0 : head.a;
    assign alu_b      = empty ? '0 : head.b;
    assign alu_opcode = empty ? '0 : head.opcode;

    // Storage needs no reset; the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= wr_cmd;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_result <= '0;
            out_opcode <= '0;
        end else if (pop) begin
            out_valid  <= 1'b1;
            out_result <= alu_result;
            out_opcode <= head.opcode;
        end else if (out_ready) begin
            out_valid  <= 1'b0;
        end
    end

`ifdef ALU_CMD_ERR_EN
    always_ff @(posedge clk) begin
        if (rst)
            out_err <= 1'b0;
        else if (pop)
            out_err <= (head.opcode[3:2] == 2'b11);
    end
`endif

endmodule

// File: tb/tb_alu_cmd_queue.sv
// Directed bench for alu_cmd_queue: vector table for flow/backpressure/full cases,
// hand sequences for reset, pointer wrap and the optional error flag.
module tb_alu_cmd_queue;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_a, in_b;
    logic [3:0] in_opcode;
    logic [7:0] alu_a, alu_b, alu_result;
    logic [3:0] alu_opcode;
    logic       out_valid, out_ready;
    logic [7:0] out_result;
    logic [3:0] out_opcode;
    logic [2:0] count;
`ifdef ALU_CMD_ERR_EN
    logic       out_err;
    assign alu_result = (alu_opcode[3:2] == 2'b11) ? 8'd0 : alu_a + alu_b;
`else
    assign alu_result = alu_a + alu_b;
`endif

    always #5 clk = ~clk;

    alu_cmd_queue #(.DATA_WIDTH(8), .OPCODE_WIDTH(4), .DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_opcode(in_opcode),
        .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode), .alu_result(alu_result),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_opcode(out_opcode),
        .count(count)
`ifdef ALU_CMD_ERR_EN
        , .out_err(out_err)
`endif
    );

    typedef struct {
        logic       iv;
        logic [7:0] a, b;
        logic [3:0] op;
        logic       ordy;
        logic       e_ov;
        logic [7:0] e_res;
        logic [3:0] e_op;
        logic [2:0] e_cnt;
    } vec_t;

    int   n_pass = 0;
    int   n_total = 0;
    vec_t vt [25];
    logic mon_en = 1'b0;
    int   got [$];

    function automatic vec_t mk(bit iv, int a, int b, int op, bit ordy,
                                bit ov, int res, int eop, int cnt);
        vec_t v;
        v.iv = iv; v.a = a[7:0]; v.b = b[7:0]; v.op = op[3:0]; v.ordy = ordy;
        v.e_ov = ov; v.e_res = res[7:0]; v.e_op = eop[3:0]; v.e_cnt = cnt[2:0];
        return v;
    endfunction

    task automatic chk(string name, int act, int exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    always @(posedge clk)
        if (mon_en && out_valid && out_ready) got.push_back(int'(out_result));

    initial begin
        int i, nc;
        logic acc;
        // iv  a   b  op ordy | ov res op cnt
        vt[0]  = mk(1,  5, 3, 0, 1,  0,  0, 0, 1);
        vt[1]  = mk(0,  0, 0, 0, 1,  1,  8, 0, 0);
        vt[2]  = mk(0,  0, 0, 0, 1,  0,  8, 0, 0);
        vt[3]  = mk(1, 10, 1, 1, 0,  0,  8, 0, 1);
        vt[4]  = mk(1, 20, 2, 2, 0,  1, 11, 1, 1);
        vt[5]  = mk(1, 30, 3, 3, 0,  1, 11, 1, 2);
        vt[6]  = mk(1, 40, 4, 4, 0,  1, 11, 1, 3);
        vt[7]  = mk(1, 50, 5, 5, 0,  1, 11, 1, 4);
        vt[8]  = mk(1, 60, 6, 6, 0,  1, 11, 1, 4);
        vt[9]  = mk(0,  0, 0, 0, 1,  1, 22, 2, 3);
        vt[10] = mk(0,  0, 0, 0, 1,  1, 33, 3, 2);
        vt[11] = mk(0,  0, 0, 0, 1,  1, 44, 4, 1);
        vt[12] = mk(0,  0, 0, 0, 1,  1, 55, 5, 0);
        vt[13] = mk(0,  0, 0, 0, 1,  0, 55, 5, 0);
        vt[14] = mk(1,  1, 1, 7, 0,  0, 55, 5, 1);
        vt[15] = mk(1,  2, 2, 8, 0,  1,  2, 7, 1);
        vt[16] = mk(1,  3, 3, 9, 0,  1,  2, 7, 2);
        vt[17] = mk(1,  4, 4,10, 0,  1,  2, 7, 3);
        vt[18] = mk(1,  5, 5,11, 0,  1,  2, 7, 4);
        vt[19] = mk(1,  6, 6,12, 1,  1,  4, 8, 3);
        vt[20] = mk(1,  6, 6,12, 1,  1,  6, 9, 3);
        vt[21] = mk(0,  0, 0, 0, 1,  1,  8,10, 2);
        vt[22] = mk(0,  0, 0, 0, 1,  1, 10,11, 1);
        vt[23] = mk(0,  0, 0, 0, 1,  1, 12,12, 0);
        vt[24] = mk(0,  0, 0, 0, 1,  0, 12,12, 0);

        rst = 1'b1; in_valid = 0; in_a = 0; in_b = 0; in_opcode = 0; out_ready = 1;
        cyc(); cyc();
        rst = 1'b0;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_result", out_result, 0);
        chk("rst_out_opcode", out_opcode, 0);
        chk("rst_count", count, 0);
        chk("rst_alu_a", alu_a, 0);
        chk("rst_alu_b", alu_b, 0);
        chk("rst_alu_opcode", alu_opcode, 0);

        for (int k = 0; k < 25; k++) begin
            in_valid = vt[k].iv; in_a = vt[k].a; in_b = vt[k].b;
            in_opcode = vt[k].op; out_ready = vt[k].ordy;
            cyc();
            chk($sformatf("v%0d_out_valid", k), out_valid, vt[k].e_ov);
            chk($sformatf("v%0d_out_result", k), out_result, vt[k].e_res);
            chk($sformatf("v%0d_out_opcode", k), out_opcode, vt[k].e_op);
            chk($sformatf("v%0d_count", k), count, vt[k].e_cnt);
            chk($sformatf("v%0d_in_ready", k), in_ready, (vt[k].e_cnt != 3'd4) ? 1 : 0);
        end

        // Reset with three queued commands and a pending result.
        out_ready = 0;
        for (int k = 0; k < 4; k++) begin
            in_valid = 1; in_a = 8'(7 + k); in_b = 1; in_opcode = 4'(k + 1);
            cyc();
        end
        in_valid = 0;
        chk("pre_rst_count", count, 3);
        chk("pre_rst_out_result", out_result, 8);
        chk("pre_rst_alu_a", alu_a, 8);
        rst = 1;
        cyc();
        rst = 0;
        chk("mid_rst_count", count, 0);
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_in_ready", in_ready, 1);
        chk("mid_rst_alu_a", alu_a, 0);
        chk("mid_rst_alu_b", alu_b, 0);
        chk("mid_rst_alu_opcode", alu_opcode, 0);
        in_valid = 1; in_a = 2; in_b = 2; in_opcode = 0; out_ready = 1;
        cyc();
        in_valid = 0;
        cyc();
        chk("post_rst_out_valid", out_valid, 1);
        chk("post_rst_out_result", out_result, 4);
        cyc();

        // Pointer wrap with toggling backpressure.
        mon_en = 1; i = 0; nc = 0;
        while ((i < 10 || got.size() < 10) && nc < 200) begin
            in_valid = (i < 10); in_a = 8'(i); in_b = 1; in_opcode = 0;
            out_ready = (nc % 2 == 0);
            acc = in_valid && in_ready;
            cyc();
            if (acc) i++;
            nc++;
        end
        mon_en = 0; in_valid = 0; out_ready = 1;
        chk("wrap_timeout", (nc < 200) ? 1 : 0, 1);
        chk("wrap_n_results", got.size(), 10);
        for (int k = 0; k < 10 && k < got.size(); k++)
            chk($sformatf("wrap_res%0d", k), got[k], k + 1);
        cyc();

`ifdef ALU_CMD_ERR_EN
        in_valid = 1; in_a = 3; in_b = 4; in_opcode = 4'b1100;
        cyc();
        in_valid = 0;
        cyc();
        chk("err_out_result", out_result, 0);
        chk("err_out_err", out_err, 1);
        in_valid = 1; in_opcode = 4'b0000;
        cyc();
        in_valid = 0;
        cyc();
        chk("ok_out_result", out_result, 7);
        chk("ok_out_err", out_err, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
